fetch_queue: RTL and testbench
==============================

# fetch_queue

Decoupled instruction-fetch front end for the pipelined RV64 core. Replaces the single-entry fetch stage and its fetch register with a PC generator, an ibus request state machine and a parametrised DEPTH-entry FIFO of fetched instructions. Sits between the ibus and decode: decode pops entries with a valid/ready handshake, and execute redirects the PC on taken branches/jumps.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, 2..16
- RESET_PC, 64'h8000_0000, first fetch address after reset

Ports:
- clk  in  1  core clock
- reset  in  1  asynchronous, active-high reset
- ireq  out  ibus_req_t  valid, addr of the instruction request
- iresp  in  ibus_resp_t  addr_ok, data_ok, data (32-bit instruction)
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc
- redirect_pc  in  64  new fetch address; bits [1:0] ignored
- deq_valid  out  1  head entry available to decode
- deq_ready  in  1  decode accepts head this cycle
- deq_pc  out  64  PC of head entry
- deq_instr  out  32  instruction of head entry
- stall_cnt  out  32  cycles with ireq.valid high and no data_ok (saturating)

## Operation
- State machine, states IDLE, FETCH, DROP:
  - IDLE: issue when count < DEPTH and no redirect this cycle; go to FETCH with ireq.addr = fetch_pc.
  - FETCH: ireq.valid and ireq.addr held constant until data_ok. On data_ok, push {ireq.addr, iresp.data}, fetch_pc += 4, then return to IDLE.
  - redirect in FETCH without data_ok: go to DROP. In DROP, ireq.valid and addr remain held. On data_ok, discard the data and go to IDLE.
  - redirect coinciding with data_ok in FETCH: discard the data and go to IDLE.
- At most one outstanding request. Issue is gated on count + outstanding < DEPTH, so a push never meets a full queue.
- redirect_valid, any state: fetch_pc <= {redirect_pc[63:2], 2'b00}. The queue is emptied in the same edge, so deq_valid = 0 the next cycle. A simultaneous pop is ignored.
- Push and pop in the same cycle: count is unchanged, and the head and tail pointers both advance.
- Pointers are log2(DEPTH)+1 bits and wrap naturally. Empty when the pointers are equal; full when only the MSB differs.
- fetch_pc arithmetic is 64-bit modulo 2^64.
- stall_cnt increments by 1 each cycle with ireq.valid=1 and data_ok=0, and saturates at 32'hFFFF_FFFF.

## Timing
- Reset values:
  - ireq.valid=0, ireq.addr=RESET_PC
  - deq_valid=0, deq_pc=0, deq_instr=0
  - stall_cnt=0, state=IDLE, queue empty
- Reset mid-request: the bus transaction is abandoned.
- ireq.valid rises 1 cycle after leaving reset; the first issue happens in the cycle after reset deassertion.
- Queue latency: data_ok in cycle N gives deq_valid=1 in cycle N+1 (registered FIFO).
- Throughput without bypass: one instruction per 2 cycles at best with a zero-wait bus (FETCH, then IDLE).
- deq_pc and deq_instr are stable while deq_valid=1 and deq_ready=0.

## Configuration
- FETCHQ_BYPASS_EN defined:
  - When the queue is empty and data_ok arrives with no redirect, the data drives deq_valid, deq_pc and deq_instr combinationally in the same cycle.
  - If deq_ready=1 in that cycle, the entry is not written; otherwise it is pushed.
  - FETCH may also issue the next request in the data_ok cycle (goes FETCH to FETCH), giving 1 instruction/cycle with a zero-wait bus.
- FETCHQ_BYPASS_EN not defined: no combinational path from iresp to deq_*. The timing above applies exactly.

## Structure
- Shared pipes package:
  - fetchq_entry_t {u64 pc; u32 instr;}
  - fetchq_state_t enum {IDLE, FETCH, DROP}
  - FETCHQ_DEFAULT_DEPTH = 4
- Sub-module fetchq_fifo (parametrised DEPTH), with:
  - push/pop/flush, full/empty/count
  - fetchq_entry_t storage
  - asynchronous reset of the pointers only
- The top module holds the FSM, fetch_pc and stall_cnt.

## Test plan
- Reset release, zero-wait bus returning 32'h00000013: first entry has deq_pc=64'h8000_0000; the next entry has 64'h8000_0004.
- deq_ready=0 with DEPTH=4: exactly 4 entries fill and then ireq.valid stays 0. One pop re-enables exactly one issue.
- redirect to 64'h8000_0103 while FETCH waits 3 cycles for data_ok:
  - the stale data is discarded and deq_valid=0;
  - the next ireq.addr is 64'h8000_0100.
- redirect in the same cycle as data_ok and deq_ready: the queue is empty next cycle and the entry is not enqueued.
- A bus with 5-cycle data_ok latency: stall_cnt increases by 4 per request; force stall_cnt near saturation and confirm it holds at 32'hFFFF_FFFF.
- With FETCHQ_BYPASS_EN, empty queue and a zero-wait bus: deq_valid is high in the data_ok cycle, and 8 consecutive instructions arrive in 8 cycles.

Source files
------------

// File: rtl/fetch_queue_pkg.sv
// fetch_queue_pkg: shared types for the fetch queue front end (FETCHQ_BYPASS_EN selects the bypass build)
package fetch_queue_pkg;
  localparam int FETCHQ_DEFAULT_DEPTH = 4;
  typedef logic [63:0] u64;
  typedef logic [31:0] u32;
  typedef struct packed {
    u64 pc;
    u32 instr;
  } fetchq_entry_t;
  typedef enum logic [1:0] {IDLE, FETCH, DROP} fetchq_state_t;
  typedef struct packed {
    logic valid;
    u64   addr;
  } ibus_req_t;
  typedef struct packed {
    logic addr_ok;
    logic data_ok;
    u32   data;
  } ibus_resp_t;
  function automatic u64 align4(input u64 a);
    return a & ~64'h3;
  endfunction
endpackage

// File: rtl/fetch_queue_fifo.sv
// fetchq_fifo: DEPTH-entry registered FIFO of fetched instructions with flush
module fetchq_fifo
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = FETCHQ_DEFAULT_DEPTH,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic          flush_i,
  input  fetchq_entry_t wdata_i,
  output fetchq_entry_t rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [AW:0]   count_o
);
  fetchq_entry_t mem_q [DEPTH];
  logic [AW:0] wp_q, wp_d, rp_q, rp_d;
  // pointer advance; flush empties the queue and overrides any pop
  always_comb begin
    wp_d = flush_i ? '0 : wp_q + {{AW{1'b0}}, push_i};
    rp_d = flush_i ? '0 : rp_q + {{AW{1'b0}}, pop_i};
  end
  // only the pointers are reset; storage contents are don't-care when empty
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wp_q <= '0;
      rp_q <= '0;
    end else begin
      wp_q <= wp_d;
      rp_q <= rp_d;
    end
  end
  // entry write at the tail
  always_ff @(posedge clk) begin
    if (push_i && !flush_i) mem_q[wp_q[AW-1:0]] <= wdata_i;
  end
  assign empty_o = wp_q == rp_q;
  assign full_o  = (wp_q ^ rp_q) == {1'b1, {AW{1'b0}}};
  assign count_o = wp_q - rp_q;
  assign rdata_o = empty_o ? '0 : mem_q[rp_q[AW-1:0]];
endmodule

// File: rtl/fetch_queue.sv
// fetch_queue: PC generator, ibus request FSM and instruction FIFO; FETCHQ_BYPASS_EN enables empty-queue bypass
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int          DEPTH    = FETCHQ_DEFAULT_DEPTH,
  parameter logic [63:0] RESET_PC = 64'h8000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output ibus_req_t   ireq,
  input  ibus_resp_t  iresp,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        deq_valid,
  input  logic        deq_ready,
  output logic [63:0] deq_pc,
  output logic [31:0] deq_instr,
  output logic [31:0] stall_cnt
);
  localparam int AW = $clog2(DEPTH);
  fetchq_state_t state_q, state_d;
  logic [63:0] pc_q, pc_d, addr_q, addr_d;
  logic [31:0] stall_q, stall_d;
  logic push, pop, accept, bypass, full, empty, unused_ok;
  logic [AW:0] count;
  fetchq_entry_t head;
  assign accept = state_q == FETCH && iresp.data_ok && !redirect_valid;
`ifdef FETCHQ_BYPASS_EN
  localparam logic [AW:0] DW = DEPTH[AW:0];
  logic [AW:0] occ;
  assign bypass    = accept && empty;
  assign occ       = count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
  assign unused_ok = iresp.addr_ok;
`else
  assign bypass    = 1'b0;
  assign unused_ok = ^{iresp.addr_ok, count};
`endif
  assign pop       = deq_ready && !empty && !redirect_valid;
  assign push      = accept && !(bypass && deq_ready);
  assign deq_valid = !empty || bypass;
  assign deq_pc    = bypass ? addr_q : head.pc;
  assign deq_instr = bypass ? iresp.data : head.instr;
  assign ireq      = '{valid: state_q != IDLE, addr: addr_q};
  assign stall_cnt = stall_q;
  fetchq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .pop_i   (pop),
    .flush_i (redirect_valid),
    .wdata_i ('{pc: addr_q, instr: iresp.data}),
    .rdata_o (head),
    .full_o  (full),
    .empty_o (empty),
    .count_o (count)
  );
  // request FSM: issue from IDLE, hold address until data_ok, drop data after a redirect
  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE: if (!redirect_valid && !full) begin
        state_d = FETCH;
        addr_d  = pc_q;
      end
      FETCH: if (iresp.data_ok) begin
        state_d = IDLE;
`ifdef FETCHQ_BYPASS_EN
        if (accept && occ != DW) begin
          state_d = FETCH;
          addr_d  = pc_q + 64'd4;
        end
`endif
      end else if (redirect_valid) state_d = DROP;
      DROP: state_d = iresp.data_ok ? IDLE : DROP;
      default: state_d = IDLE;
    endcase
  end
  // fetch PC and saturating stall counter
  always_comb begin
    pc_d    = redirect_valid ? align4(redirect_pc) : accept ? pc_q + 64'd4 : pc_q;
    stall_d = (ireq.valid && !iresp.data_ok && stall_q != '1) ? stall_q + 32'd1 : stall_q;
  end
  // state registers; reset abandons any bus transaction in flight
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      addr_q  <= addr_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_fetch_queue.sv
// tb_fetch_queue: directed self-checking bench for fetch_queue with a variable-latency ibus model
module tb_fetch_queue;
  import fetch_queue_pkg::*;
  logic clk = 1'b0, reset = 1'b1, redirect_valid = 1'b0, deq_ready = 1'b0;
  logic [63:0] redirect_pc = '0;
  ibus_req_t ireq;
  ibus_resp_t iresp;
  logic deq_valid;
  logic [63:0] deq_pc;
  logic [31:0] deq_instr, stall_cnt;
  int checks = 0, failures = 0, lat = 1, w;
  fetch_queue #(.DEPTH(4), .RESET_PC(64'h8000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .ireq           (ireq),
    .iresp          (iresp),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .deq_valid      (deq_valid),
    .deq_ready      (deq_ready),
    .deq_pc         (deq_pc),
    .deq_instr      (deq_instr),
    .stall_cnt      (stall_cnt)
  );
  always #5 clk = ~clk;
  // bus returns data on the lat-th cycle that the request is held valid
  assign iresp.addr_ok = ireq.valid;
  assign iresp.data_ok = ireq.valid && (w >= lat - 1);
  assign iresp.data    = {ireq.addr[25:2], 8'h13};
  always @(posedge clk or posedge reset)
    if (reset) w <= 0;
    else w <= (ireq.valid && !iresp.data_ok) ? w + 1 : 0;
  function automatic logic [31:0] ins(input logic [63:0] a);
    return {a[25:2], 8'h13};
  endfunction
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  initial begin
    tick;
    tick;
    chk("rst_ireq_valid", 64'(ireq.valid), 64'd0);
    chk("rst_ireq_addr", ireq.addr, 64'h8000_0000);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_deq_pc", deq_pc, 64'd0);
    chk("rst_deq_instr", 64'(deq_instr), 64'd0);
    chk("rst_stall", 64'(stall_cnt), 64'd0);
    reset = 1'b0;
`ifdef FETCHQ_BYPASS_EN
    deq_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick;
      chk("byp_valid", 64'(deq_valid), 64'd1);
      chk("byp_pc", deq_pc, 64'h8000_0000 + 64'(4 * i));
      chk("byp_instr", 64'(deq_instr), 64'(ins(64'h8000_0000 + 64'(4 * i))));
    end
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0102;
    tick;
    redirect_valid = 1'b0;
    chk("byp_redir_valid", 64'(deq_valid), 64'd0);
    chk("byp_redir_req", 64'(ireq.valid), 64'd0);
    tick;
    chk("byp_after_redir_pc", deq_pc, 64'h8000_0100);
    chk("byp_after_redir_valid", 64'(deq_valid), 64'd1);
    deq_ready = 1'b0;
    tick;
    chk("byp_held_pc", deq_pc, 64'h8000_0100);
    chk("byp_next_addr", ireq.addr, 64'h8000_0104);
`else
    tick;
    chk("first_req_valid", 64'(ireq.valid), 64'd1);
    chk("first_req_addr", ireq.addr, 64'h8000_0000);
    chk("first_deq_valid", 64'(deq_valid), 64'd0);
    tick;
    chk("lat_deq_valid", 64'(deq_valid), 64'd1);
    chk("lat_deq_pc", deq_pc, 64'h8000_0000);
    chk("lat_deq_instr", 64'(deq_instr), 64'h0000_0013);
    chk("idle_gap", 64'(ireq.valid), 64'd0);
    tick;
    chk("second_req_addr", ireq.addr, 64'h8000_0004);
    tick;
    chk("stable_pc", deq_pc, 64'h8000_0000);
    repeat (4) tick;
    chk("full_no_issue0", 64'(ireq.valid), 64'd0);
    repeat (2) begin
      tick;
      chk("full_no_issue", 64'(ireq.valid), 64'd0);
    end
    chk("full_head_pc", deq_pc, 64'h8000_0000);
    deq_ready = 1'b1;
    tick;
    deq_ready = 1'b0;
    chk("pop_head_pc", deq_pc, 64'h8000_0004);
    chk("pop_same_cycle_req", 64'(ireq.valid), 64'd0);
    tick;
    chk("refill_req_valid", 64'(ireq.valid), 64'd1);
    chk("refill_req_addr", ireq.addr, 64'h8000_0010);
    repeat (3) begin
      tick;
      chk("refill_once", 64'(ireq.valid), 64'd0);
    end
    lat = 4;
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0043;
    tick;
    redirect_valid = 1'b0;
    chk("flush_deq_valid", 64'(deq_valid), 64'd0);
    chk("flush_no_issue", 64'(ireq.valid), 64'd0);
    tick;
    chk("redir_req_addr", ireq.addr, 64'h8000_0040);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0103;
    tick;
    redirect_valid = 1'b0;
    chk("drop_valid_held", 64'(ireq.valid), 64'd1);
    chk("drop_addr_held", ireq.addr, 64'h8000_0040);
    repeat (3) tick;
    chk("drop_discard", 64'(deq_valid), 64'd0);
    chk("drop_idle", 64'(ireq.valid), 64'd0);
    tick;
    chk("redir_new_addr", ireq.addr, 64'h8000_0100);
    repeat (4) tick;
    chk("redir_deq_valid", 64'(deq_valid), 64'd1);
    chk("redir_deq_pc", deq_pc, 64'h8000_0100);
    chk("redir_deq_instr", 64'(deq_instr), 64'h0000_4013);
    chk("stall_after_waits", 64'(stall_cnt), 64'd6);
    lat = 1;
    tick;
    chk("race_req_addr", ireq.addr, 64'h8000_0104);
    redirect_valid = 1'b1;
    redirect_pc = 64'h8000_0200;
    deq_ready = 1'b1;
    tick;
    redirect_valid = 1'b0;
    deq_ready = 1'b0;
    chk("race_empty", 64'(deq_valid), 64'd0);
    chk("race_idle", 64'(ireq.valid), 64'd0);
    tick;
    chk("race_next_addr", ireq.addr, 64'h8000_0200);
    tick;
    chk("race_not_enqueued", deq_pc, 64'h8000_0200);
    chk("stall_zero_wait", 64'(stall_cnt), 64'd6);
    lat = 5;
    deq_ready = 1'b1;
    repeat (6) tick;
    chk("stall_req1", 64'(stall_cnt), 64'd10);
    chk("stall_req1_pc", deq_pc, 64'h8000_0204);
    repeat (6) tick;
    chk("stall_req2", 64'(stall_cnt), 64'd14);
    chk("stall_req2_pc", deq_pc, 64'h8000_0208);
    tick;
    force dut.stall_q = 32'hFFFF_FFFD;
    tick;
    release dut.stall_q;
    repeat (3) tick;
    chk("stall_saturate", 64'(stall_cnt), 64'hFFFF_FFFF);
    repeat (6) tick;
    chk("stall_hold", 64'(stall_cnt), 64'hFFFF_FFFF);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
